// File: rtl/pll_lock_sequencer.sv
// Power-up / lock-recovery sequencer for the PH1P PLL, clocked by the free-running reference clock.
// Optional: define PLL_SEQ_LOSS_CNT_EN to build the saturating RUN-state lock-loss counter on loss_cnt.
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYC = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int STABLE_CYC   = 256,
    parameter int MAX_RETRY    = 7,
    parameter int CNT_W        = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       out_rst_n,
    output logic       locked,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [2:0] state_o,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRY);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lock_meta;
    logic             lock_s;

    // NOTE: non-blocking assignments make each stage sample the pre-edge value;
    // blocking ones would collapse the two synchroniser flops into a single stage.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    assign state_o = state;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pll_reset <= 1'b1;
            out_rst_n <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
        end else if (!enable) begin
            // Power-down beats every other transition, including a coincident lock loss.
            state     <= S_IDLE;
            cnt       <= '0;
            pll_reset <= 1'b1;
            out_rst_n <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_RESET;
                    cnt       <= '0;
                    retry_cnt <= '0;
                    pll_reset <= 1'b1;
                end
                S_RESET: begin
                    if (cnt == HOLD_LAST) begin
                        state     <= S_WAIT_LOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    pll_reset <= 1'b0;
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        if (retry_cnt == RETRY_LIMIT) begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state     <= S_RESET;
                            retry_cnt <= (retry_cnt == 3'd7) ? retry_cnt : retry_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_STABLE: begin
                    // A drop here is a glitch: requalify without a new PLL reset or retry.
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state  <= S_RUN;
                        cnt    <= '0;
                        locked <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state     <= S_RESET;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        out_rst_n <= 1'b0;
                        locked    <= 1'b0;
                        retry_cnt <= '0;
                    end else begin
                        out_rst_n <= 1'b1;
                        locked    <= 1'b1;
                    end
                end
                S_FAIL: begin
                    pll_reset <= 1'b1;
                    out_rst_n <= 1'b0;
                    fail      <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    out_rst_n <= 1'b0;
                    locked    <= 1'b0;
                    fail      <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic loss_event;

    assign loss_event = (state == S_RUN) && !lock_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt <= '0;
        end else if (loss_event && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: phase/age reference model compared every cycle,
// plus literal timing expectations for bring-up, retries, failure, glitches, losses and async reset.
module tb_pll_lock_sequencer;

    localparam int RST_HOLD = 16;
    localparam int TMO      = 4000;
    localparam int STAB     = 256;
    localparam int MAXR     = 7;
    // Edges from the first edge that samples a new lock to RUN: 2 sync + 1 WAIT_LOCK + STAB.
    localparam int LOCK_TO_RUN = 3 + STAB;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RESET  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_STABLE = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    localparam int P_STATE = 0;
    localparam int P_PRST  = 1;
    localparam int P_ORST  = 2;

`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       enable   = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       out_rst_n;
    logic       locked;
    logic       fail;
    logic [2:0] retry_cnt;
    logic [2:0] state_o;
    logic [7:0] loss_cnt;

    int checks   = 0;
    int failures = 0;

    pll_lock_sequencer #(
        .RST_HOLD_CYC(RST_HOLD),
        .LOCK_TIMEOUT(TMO),
        .STABLE_CYC  (STAB),
        .MAX_RETRY   (MAXR),
        .CNT_W       (16)
    ) dut (
        .refclk   (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .out_rst_n(out_rst_n),
        .locked   (locked),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .state_o  (state_o),
        .loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase we are in, how many edges we have spent there,
    // and what pll_lock looked like two edges ago.
    int m_phase = 0;
    int m_age   = 0;
    int m_retry = 0;
    int m_loss  = 0;
    bit m_h0    = 1'b0;
    bit m_h1    = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int nxt;
        int retry_n;
        int loss_n;
        bit seen;
        if (!rst_n) begin
            m_phase <= 0;
            m_age   <= 0;
            m_retry <= 0;
            m_loss  <= 0;
            m_h0    <= 1'b0;
            m_h1    <= 1'b0;
        end else begin
            seen    = m_h1;
            nxt     = m_phase;
            retry_n = m_retry;
            loss_n  = m_loss;
            if (!enable) begin
                if (m_phase == ST_RUN && !seen) loss_n = (m_loss < 255) ? m_loss + 1 : 255;
                nxt = ST_IDLE;
            end else begin
                case (m_phase)
                    ST_IDLE: begin
                        nxt     = ST_RESET;
                        retry_n = 0;
                    end
                    ST_RESET: if (m_age == RST_HOLD - 1) nxt = ST_WAIT;
                    ST_WAIT: begin
                        if (seen) nxt = ST_STABLE;
                        else if (m_age == TMO - 1) begin
                            if (m_retry == MAXR) nxt = ST_FAIL;
                            else begin
                                nxt     = ST_RESET;
                                retry_n = (m_retry < 7) ? m_retry + 1 : 7;
                            end
                        end
                    end
                    ST_STABLE: begin
                        if (!seen) nxt = ST_WAIT;
                        else if (m_age == STAB - 1) nxt = ST_RUN;
                    end
                    ST_RUN: begin
                        if (!seen) begin
                            nxt     = ST_RESET;
                            retry_n = 0;
                            loss_n  = (m_loss < 255) ? m_loss + 1 : 255;
                        end
                    end
                    default: ;
                endcase
            end
            m_h1    <= m_h0;
            m_h0    <= pll_lock;
            m_age   <= (nxt == m_phase) ? m_age + 1 : 0;
            m_phase <= nxt;
            m_retry <= retry_n;
            m_loss  <= LOSS_EN ? loss_n : 0;
        end
    end

    // Every cycle: {state, pll_reset, out_rst_n, locked, fail, retry_cnt, loss_cnt}.
    always @(negedge clk) begin : compare
        logic [17:0] exp_v;
        logic [17:0] act_v;
        exp_v = {3'(m_phase),
                 (m_phase == ST_IDLE || m_phase == ST_RESET || m_phase == ST_FAIL),
                 (m_phase == ST_RUN && m_age >= 1),
                 (m_phase == ST_RUN),
                 (m_phase == ST_FAIL),
                 3'(m_retry),
                 8'(m_loss)};
        act_v = {state_o, pll_reset, out_rst_n, locked, fail, retry_cnt, loss_cnt};
        check("cycle_outputs", 32'(act_v), 32'(exp_v));
    end

    function automatic logic [2:0] probe(input int which);
        case (which)
            P_STATE: return state_o;
            P_PRST:  return {2'b00, pll_reset};
            default: return {2'b00, out_rst_n};
        endcase
    endfunction

    // Counts edges until the probed signal equals val (sampled at the following negedge).
    task automatic wait_until(input string name, input int which, input logic [2:0] val,
                              input int budget, output int n, output bit saw_prst);
        n        = 0;
        saw_prst = 1'b0;
        while (1) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (pll_reset) saw_prst = 1'b1;
            if (probe(which) == val) return;
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL %s: timed out after %0d cycles, last 0x%0h, required 0x%0h",
                         name, n, probe(which), val);
                return;
            end
        end
    endtask

    // Called at a negedge where the probed signal equals val; returns its run length in cycles.
    task automatic run_length(input string name, input int which, input logic [2:0] val,
                              input int budget, output int n);
        n = 1;
        forever begin
            @(negedge clk);
            if (probe(which) != val) return;
            n++;
            if (n > budget) begin
                checks++;
                failures++;
                $display("FAIL %s: still 0x%0h after %0d cycles, required a change", name, val, n);
                return;
            end
        end
    endtask

    initial begin
        int n;
        bit sp;

        repeat (3) @(negedge clk);
        check("reset_state", state_o, ST_IDLE);
        check("reset_pll_reset", pll_reset, 1);
        check("reset_out_rst_n", out_rst_n, 0);
        check("reset_locked", locked, 0);
        check("reset_fail", fail, 0);
        check("reset_retry", retry_cnt, 0);
        check("reset_loss", loss_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_while_disabled", state_o, ST_IDLE);

        // Normal bring-up, lock 1000 cycles after pll_reset falls.
        enable = 1'b1;
        wait_until("bringup_reset", P_STATE, ST_RESET, 4, n, sp);
        check("bringup_enter_latency", n, 1);
        run_length("bringup_hold", P_PRST, 1, 100, n);
        check("bringup_pll_reset_width", n, RST_HOLD);
        check("bringup_after_hold", state_o, ST_WAIT);
        repeat (999) @(negedge clk);
        pll_lock = 1'b1;
        wait_until("bringup_run", P_STATE, ST_RUN, 2 * STAB, n, sp);
        check("bringup_lock_to_run", n, LOCK_TO_RUN);
        check("bringup_out_rst_n_on_entry", out_rst_n, 0);
        check("bringup_locked", locked, 1);
        @(negedge clk);
        check("bringup_out_rst_n_released", out_rst_n, 1);
        check("bringup_retry", retry_cnt, 0);

        // Lock lost in RUN for 5 cycles.
        pll_lock = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                pll_lock = 1'b1;
            end
        join_none
        wait_until("loss_out_rst", P_ORST, 0, 10, n, sp);
        check("loss_out_rst_latency", n, 3);
        check("loss_state", state_o, ST_RESET);
        check("loss_locked", locked, 0);
        check("loss_cnt_after_loss", loss_cnt, LOSS_EN ? 1 : 0);
        run_length("loss_hold", P_PRST, 1, 100, n);
        check("loss_pll_reset_width", n, RST_HOLD);

        // Three-cycle glitch at stable count 100.
        wait_until("glitch_stable", P_STATE, ST_STABLE, 4, n, sp);
        check("glitch_enter_stable", n, 1);
        repeat (100) @(negedge clk);
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        pll_lock = 1'b1;
        check("glitch_back_to_wait", state_o, ST_WAIT);
        check("glitch_pll_reset_low", pll_reset, 0);
        wait_until("glitch_requal", P_STATE, ST_RUN, 2 * STAB, n, sp);
        check("glitch_requal_time", n, LOCK_TO_RUN);
        check("glitch_no_new_pulse", sp, 0);
        check("glitch_retry", retry_cnt, 0);

        // Lock loss in RUN coinciding with enable dropping.
        @(negedge clk);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("coinc_loss_idle", state_o, ST_IDLE);
        check("coinc_loss_counted", loss_cnt, LOSS_EN ? 2 : 0);
        check("coinc_loss_pll_reset", pll_reset, 1);
        check("coinc_loss_out_rst_n", out_rst_n, 0);

        // Two timeouts, then lock 100 cycles into attempt 3.
        enable = 1'b1;
        wait_until("retry_reset", P_STATE, ST_RESET, 4, n, sp);
        for (int a = 0; a < 2; a++) begin
            run_length("retry_high", P_PRST, 1, 100, n);
            check("retry_pulse_width", n, RST_HOLD);
            run_length("retry_low", P_PRST, 0, 2 * TMO, n);
            check("retry_pulse_gap", n, TMO);
        end
        run_length("retry_high3", P_PRST, 1, 100, n);
        check("retry_pulse_width3", n, RST_HOLD);
        check("retry_cnt_attempt3", retry_cnt, 2);
        repeat (99) @(negedge clk);
        pll_lock = 1'b1;
        wait_until("retry_run", P_STATE, ST_RUN, 2 * STAB, n, sp);
        check("retry_lock_to_run", n, LOCK_TO_RUN);
        check("retry_cnt_in_run", retry_cnt, 2);

        // Permanent failure with lock stuck low.
        pll_lock = 1'b0;
        enable   = 1'b0;
        @(negedge clk);
        check("fail_pre_idle", state_o, ST_IDLE);
        enable = 1'b1;
        wait_until("fail_reach", P_STATE, ST_FAIL, 40000, n, sp);
        check("fail_time", n, 1 + (MAXR + 1) * (RST_HOLD + TMO));
        check("fail_flag", fail, 1);
        check("fail_pll_reset", pll_reset, 1);
        check("fail_retry", retry_cnt, 7);
        repeat (10) @(negedge clk);
        check("fail_sticky", state_o, ST_FAIL);
        enable = 1'b0;
        @(negedge clk);
        check("fail_exit_idle", state_o, ST_IDLE);
        check("fail_cleared", fail, 0);
        enable = 1'b1;
        @(negedge clk);
        check("fail_restart_reset", state_o, ST_RESET);
        check("fail_restart_retry", retry_cnt, 0);

        // Lock arriving on the exact timeout edge wins over the retry.
        wait_until("coinc_wait", P_STATE, ST_WAIT, 40, n, sp);
        repeat (TMO - 3) @(posedge clk);
        #1 pll_lock = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("coinc_lock_wins", state_o, ST_STABLE);
        check("coinc_retry", retry_cnt, 0);

        // Asynchronous reset deep into WAIT_LOCK.
        wait_until("ar_run", P_STATE, ST_RUN, 2 * STAB, n, sp);
        pll_lock = 1'b0;
        wait_until("ar_wait", P_STATE, ST_WAIT, 100, n, sp);
        repeat (3000) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_state", state_o, ST_IDLE);
        check("ar_pll_reset", pll_reset, 1);
        check("ar_out_rst_n", out_rst_n, 0);
        check("ar_locked", locked, 0);
        check("ar_fail", fail, 0);
        check("ar_retry", retry_cnt, 0);
        check("ar_loss", loss_cnt, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_until("ar_reset", P_STATE, ST_RESET, 4, n, sp);
        check("ar_restart_latency", n, 1);
        run_length("ar_hold", P_PRST, 1, 100, n);
        check("ar_pll_reset_width", n, RST_HOLD);
        check("ar_after_hold", state_o, ST_WAIT);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
